// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
//
// Receive-side frame controller. Each accepted frame is checked in a single
// CHECK cycle. The controller answers each frame with exactly one registered
// pulse:
//   - ack        : the frame is good, and its data is pushed into a 4-entry
//                  show-ahead FIFO.
//   - nak        : the frame is bad, and the sender is asked to retransmit.
//   - retry_fail : the frame is bad after MAX_RETRY consecutive NAKs, and it
//                  is dropped.
//
// Frame format: [9:7] checksum, [6:0] data.
// A frame is good when its checksum field equals popcount(data[5:0]) ^ 3'b111.
// Bit 6 of the data field is carried to the output but is not covered by the
// checksum.
//
// Optional feature (macro RX_ERR_CNT_EN):
//   - adds the output err_cnt, an 8-bit saturating count of nak and
//     retry_fail pulses.
//
// Parameters:
//   MAX_RETRY  NAKs issued before a frame is abandoned (legal range 1..7)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    in_frame holds a received frame
//   in_ready    controller accepts a frame this cycle
//   in_frame    received frame {checksum[2:0], data[6:0]}
//   ack         one-cycle pulse, last frame good
//   nak         one-cycle pulse, last frame bad, retransmit requested
//   retry_fail  one-cycle pulse, frame abandoned
//   out_valid   FIFO head is valid
//   out_ready   consumer takes the FIFO head this cycle
//   out_data    FIFO head data
//   busy        FSM is in CHECK
//   err_cnt     (RX_ERR_CNT_EN only) saturating error-pulse count
// -----------------------------------------------------------------------------
module rx_frame_ctrl #(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_frame,
    output logic       ack,
    output logic       nak,
    output logic       retry_fail,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_data,
    output logic       busy
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [9:0] frame_q;
    logic       accept;
    logic       frame_good;
    logic       push;
    logic       pop;

    logic [2:0] retry_q;
    logic [2:0] count_q;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [6:0] mem [4];

    function automatic logic [2:0] calc_checksum(input logic [5:0] bits);
        logic [2:0] ones;
        ones = '0;
        for (int i = 0; i < 6; i++) begin
            ones = ones + {2'b00, bits[i]};
        end
        return ones ^ 3'b111;
    endfunction

    // in_ready is gated by rst_n so that it reads 0 throughout reset, even
    // before the first reset edge has settled the state register.
    assign in_ready   = rst_n && (state == IDLE) && (count_q < 3'd4);
    assign accept     = in_valid && in_ready;
    assign busy       = (state == CHECK);
    assign frame_good = (calc_checksum(frame_q[5:0]) == frame_q[9:7]);

    // The FIFO cannot be full here. A frame is only accepted while
    // count < 4, and the count cannot grow while the FSM is in CHECK.
    assign push       = busy && frame_good;
    assign out_valid  = (count_q != 3'd0);
    assign pop        = out_valid && out_ready;
    assign out_data   = rst_n ? mem[rd_ptr] : 7'b0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so that all
    // registers update together from their pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default is assigned before the case statement so that every
    // path drives state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The frame register is a pure datapath register and has no reset.
    // It is only read while in CHECK, and entering CHECK always loads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_q <= in_frame;
        end
    end

    // ------------------------------------------------------------------
    // Response pulses and retry count
    // ------------------------------------------------------------------
    // CHECK lasts exactly one cycle, so clearing the pulses every cycle
    // and setting at most one of them in CHECK keeps each of them one cycle
    // wide and mutually exclusive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack        <= 1'b0;
            nak        <= 1'b0;
            retry_fail <= 1'b0;
            retry_q    <= 3'd0;
        end else begin
            ack        <= 1'b0;
            nak        <= 1'b0;
            retry_fail <= 1'b0;
            if (busy) begin
                if (frame_good) begin
                    ack     <= 1'b1;
                    retry_q <= 3'd0;
                end else if (retry_q < RETRY_LIMIT) begin
                    nak     <= 1'b1;
                    retry_q <= retry_q + 3'd1;
                end else begin
                    retry_fail <= 1'b1;
                    retry_q    <= 3'd0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // 4-entry show-ahead FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset. The pointers and
    // count are reset, and a slot is never read before it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= frame_q[6:0];
        end
    end

`ifdef RX_ERR_CNT_EN
    // ------------------------------------------------------------------
    // Saturating error counter
    // ------------------------------------------------------------------
    // The counter updates on the same edge that raises nak or retry_fail, so
    // it already includes the new error in the pulse cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (busy && !frame_good && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_ctrl
//
// Self-checking bench for rx_frame_ctrl.
//
// Scoreboard structure:
//   - When the driver presents a frame, it computes the expected response
//     pulse and queues it.
//   - When the frame's CHECK cycle completes, the driver queues any expected
//     FIFO data.
//   - A monitor on the falling edge pops and compares both queues as the DUT
//     produces pulses and FIFO pops.
//
// Define RX_ERR_CNT_EN to also exercise err_cnt.
// -----------------------------------------------------------------------------
module tb_rx_frame_ctrl;

    localparam int unsigned MAX_RETRY = 3;
    localparam int          BUDGET    = 200;

    typedef enum int {
        P_ACK  = 0,
        P_NAK  = 1,
        P_FAIL = 2
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_frame;
    logic       ack;
    logic       nak;
    logic       retry_fail;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_data;
    logic       busy;
`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt;
    int         m_err = 0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_retry  = 0;
    bit         mon_en   = 1'b0;

    pulse_t     exp_pulse [$];
    logic [6:0] exp_data  [$];

    rx_frame_ctrl #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_frame   (in_frame),
        .ack        (ack),
        .nak        (nak),
        .retry_fail (retry_fail),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
`ifdef RX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_good(input logic [9:0] f);
        return ((3'($countones(f[5:0])) ^ 3'b111) == f[9:7]);
    endfunction

    function automatic logic [9:0] make_frame(input logic [6:0] d, input bit good);
        logic [2:0] c;
        c = 3'($countones(d[5:0])) ^ 3'b111;
        if (!good) c = c ^ 3'(1 + ($urandom % 7));
        return {c, d};
    endfunction

    // Drive one frame, then return one cycle after the CHECK cycle ends.
    task automatic send(input logic [9:0] f);
        int     n;
        bit     was_empty;
        pulse_t k;

        n = 0;
        @(negedge clk);
        while (!in_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end

        in_frame = f;
        in_valid = 1'b1;
        if (is_good(f)) begin
            k       = P_ACK;
            m_retry = 0;
        end else if (m_retry < MAX_RETRY) begin
            k       = P_NAK;
            m_retry = m_retry + 1;
        end else begin
            k       = P_FAIL;
            m_retry = 0;
        end
        exp_pulse.push_back(k);

        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_in_check", busy, 1);

        @(posedge clk);
        #1;
        check("pulse_latency", {31'd0, ack | nak | retry_fail}, 1);
        check("busy_after_check", busy, 0);
        if (k == P_ACK) begin
            was_empty = (exp_data.size() == 0);
            exp_data.push_back(f[6:0]);
            check("out_valid_latency", out_valid, 1);
            if (was_empty) check("out_data_latency", out_data, f[6:0]);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        out_ready = v;
    endtask

    task automatic drain();
        int n;
        set_ready(1'b1);
        n = 0;
        while (exp_data.size() != 0 && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", exp_data.size(), 0);
    endtask

    // Scoreboard monitor: compare away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            pulse_t got_k;
            pulse_t want_k;

            check("out_valid_vs_model", out_valid, (exp_data.size() != 0));

            if (ack | nak | retry_fail) begin
                check("pulse_onehot", {29'd0, ack, nak, retry_fail} & ({29'd0, ack, nak, retry_fail} - 1), 0);
                got_k = ack ? P_ACK : (nak ? P_NAK : P_FAIL);
                if (exp_pulse.size() == 0) begin
                    check("unexpected_pulse", got_k, 32'hFFFF_FFFF);
                end else begin
                    want_k = exp_pulse.pop_front();
                    check("pulse_kind", got_k, want_k);
                end
`ifdef RX_ERR_CNT_EN
                if (!ack && m_err < 255) m_err++;
                check("err_cnt", err_cnt, m_err);
`endif
            end

            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    check("unexpected_pop", out_data, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", out_data, exp_data.pop_front());
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_frame  = '0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   in_ready, 0);
        check("rst_out_data",   out_data, 0);
        check("rst_out_valid",  out_valid, 0);
        check("rst_pulses",     {29'd0, ack, nak, retry_fail}, 0);
        check("rst_busy",       busy, 0);
`ifdef RX_ERR_CNT_EN
        check("rst_err_cnt",    err_cnt, 0);
`endif
        rst_n = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        mon_en = 1'b1;

        // Good frame with a known-answer data value.
        send(10'b1000000111);
        drain();

        // Four bad frames: nak, nak, nak, retry_fail, and nothing is queued.
        for (int i = 0; i < 4; i++) send(10'b0000000111);
        @(negedge clk);
        check("bad_fifo_empty", out_valid, 0);

        // bad, bad, good, then bad again: the last must be a nak.
        send(make_frame(7'h15, 1'b0));
        send(make_frame(7'h2A, 1'b0));
        send(make_frame(7'h40, 1'b1));
        send(make_frame(7'h33, 1'b0));
        drain();

        // Fill the FIFO with the consumer stalled.
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) send(make_frame(7'(8'h10 + i), 1'b1));
        check("full_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("full_hold_in_ready", in_ready, 0);
        set_ready(1'b1);
        set_ready(1'b0);
        check("pop_in_ready", in_ready, 1);
        // Push and pop in the same cycle.
        out_ready = 1'b1;
        send(make_frame(7'h7F, 1'b1));
        drain();

        // Mixed random traffic.
        for (int i = 0; i < 40; i++) begin
            send(make_frame(7'($urandom), ($urandom % 3) != 0));
        end
        drain();

        // Reset during CHECK of a good frame.
        @(negedge clk);
        in_frame = 10'b1000000111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rstchk_busy", busy, 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        check("rstchk_no_ack",   ack, 0);
        check("rstchk_out_valid", out_valid, 0);
        check("rstchk_in_ready", in_ready, 0);
        m_retry = 0;
`ifdef RX_ERR_CNT_EN
        m_err = 0;
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstrel_no_ack",   {29'd0, ack, nak, retry_fail}, 0);
        check("rstrel_out_valid", out_valid, 0);
        check("rstrel_in_ready", in_ready, 1);
        mon_en = 1'b1;

`ifdef RX_ERR_CNT_EN
        // Saturation of err_cnt.
        for (int i = 0; i < 300; i++) send(make_frame(7'($urandom), 1'b0));
        @(negedge clk);
        check("err_cnt_sat", err_cnt, 255);
        send(make_frame(7'h01, 1'b0));
        @(negedge clk);
        check("err_cnt_hold", err_cnt, 255);
`endif

        // Check that every expected response was observed.
        repeat (3) @(posedge clk);
        check("sb_pulse_empty", exp_pulse.size(), 0);
        check("sb_data_empty",  exp_data.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
